// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the five-stage core.
// It drives the pipeline-register stall and clear inputs and the EX operand
// forwarding selects. It also runs the post-reset boot flush and freezes the
// pipeline while a data-memory access is outstanding, with a timeout guard.
module pipeline_hazard_ctrl #(
    parameter int BOOT_FLUSH_CYCLES = 2,
    parameter int MEM_TIMEOUT       = 64,
    parameter int CNT_W             = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [4:0]       de_rs1,
    input  logic [4:0]       de_rs2,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_is_load,
    input  logic             ex_pc_src,
    input  logic [4:0]       mem_rd,
    input  logic             mem_reg_write,
    input  logic [4:0]       wb_rd,
    input  logic             wb_reg_write,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             if_stall,
    output logic             de_stall,
    output logic             ex_stall,
    output logic             mem_stall,
    output logic             de_clear,
    output logic             ex_clear,
    output logic             wb_clear,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int BOOT_W = $clog2(BOOT_FLUSH_CYCLES + 1);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT);

    typedef enum logic [1:0] {BOOT, RUN, MEM_WAIT} state_t;

    state_t            state, state_nxt;
    logic [BOOT_W-1:0] boot_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              req_block;    // set by a timeout until mem_req drops
    logic              freeze;
    logic              hazard_en;    // branch/load-use rules are evaluated
    logic              branch_flush;
    logic              timeout;
    logic              load_use;
    logic              boot_done;

    assign load_use  = ex_is_load && (ex_rd != 5'd0) &&
                       ((ex_rd == de_rs1) || (ex_rd == de_rs2));
    assign boot_done = (boot_cnt == BOOT_W'(BOOT_FLUSH_CYCLES - 1));

    // Next-state logic and pipeline control decode
    always_comb begin
        state_nxt    = state;
        freeze       = 1'b0;
        hazard_en    = 1'b0;
        branch_flush = 1'b0;
        timeout      = 1'b0;
        if_stall     = 1'b0;
        de_stall     = 1'b0;
        ex_stall     = 1'b0;
        mem_stall    = 1'b0;
        de_clear     = 1'b0;
        ex_clear     = 1'b0;
        wb_clear     = 1'b0;
        case (state)
            BOOT: begin
                de_clear = 1'b1;
                ex_clear = 1'b1;
                if (boot_done) state_nxt = RUN;
            end
            RUN: begin
                if (mem_req && !mem_ack && !req_block) begin
                    freeze    = 1'b1;
                    state_nxt = MEM_WAIT;
                end else begin
                    hazard_en = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (mem_ack) begin
                    // Freeze drops on the ack cycle; normal hazards resume at once.
                    hazard_en = 1'b1;
                    state_nxt = RUN;
                end else begin
                    freeze = 1'b1;
                    if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 2)) begin
                        timeout   = 1'b1;
                        state_nxt = RUN;
                    end
                end
            end
            default: state_nxt = BOOT;
        endcase

        if (freeze) begin
            if_stall  = 1'b1;
            de_stall  = 1'b1;
            ex_stall  = 1'b1;
            mem_stall = 1'b1;
            wb_clear  = 1'b1;
        end else if (hazard_en) begin
            if (ex_pc_src) begin
                // The DE instruction is squashed, so any load-use hazard is moot.
                branch_flush = 1'b1;
                de_clear     = 1'b1;
                ex_clear     = 1'b1;
            end else if (load_use) begin
                if_stall = 1'b1;
                de_stall = 1'b1;
                ex_clear = 1'b1;
            end
        end
    end

    // EX forwarding selects; MEM result is newer than WB so it wins
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (mem_reg_write && mem_rd != 5'd0 && mem_rd == ex_rs1)    fwd_a = 2'b10;
        else if (wb_reg_write && wb_rd != 5'd0 && wb_rd == ex_rs1)  fwd_a = 2'b01;
        if (mem_reg_write && mem_rd != 5'd0 && mem_rd == ex_rs2)    fwd_b = 2'b10;
        else if (wb_reg_write && wb_rd != 5'd0 && wb_rd == ex_rs2)  fwd_b = 2'b01;
    end

    // State, boot/wait counters, timeout bookkeeping
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= BOOT;
            boot_cnt  <= '0;
            wait_cnt  <= '0;
            req_block <= 1'b0;
            mem_error <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == BOOT && !boot_done) boot_cnt <= boot_cnt + 1'b1;
            if (state == MEM_WAIT && !mem_ack && !timeout) wait_cnt <= wait_cnt + 1'b1;
            else                                           wait_cnt <= '0;
            req_block <= timeout | (req_block & mem_req);
            mem_error <= mem_error | timeout;
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (if_stall && stall_cycles != '1)    stall_cycles <= stall_cycles + 1'b1;
            if (branch_flush && flush_count != '1) flush_count  <= flush_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (BOOT=2, timeout=4, 4-bit counters).
module tb_pipeline_hazard_ctrl;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [4:0]    de_rs1, de_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic          ex_is_load, ex_pc_src, mem_reg_write, wb_reg_write;
    logic          mem_req, mem_ack;
    logic          if_stall, de_stall, ex_stall, mem_stall;
    logic          de_clear, ex_clear, wb_clear;
    logic [1:0]    fwd_a, fwd_b;
    logic          mem_error;
    logic [CW-1:0] stall_cycles, flush_count;

    int checks   = 0;
    int failures = 0;

    // {if_stall, de_stall, ex_stall, mem_stall, de_clear, ex_clear, wb_clear}
    localparam logic [6:0] C_NONE   = 7'b0000000;
    localparam logic [6:0] C_FLUSH  = 7'b0000110;
    localparam logic [6:0] C_LDUSE  = 7'b1100010;
    localparam logic [6:0] C_FREEZE = 7'b1111001;

    logic [6:0] ctrl;
    assign ctrl = {if_stall, de_stall, ex_stall, mem_stall, de_clear, ex_clear, wb_clear};

    pipeline_hazard_ctrl #(
        .BOOT_FLUSH_CYCLES(2),
        .MEM_TIMEOUT(4),
        .CNT_W(CW)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .de_rs1(de_rs1), .de_rs2(de_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_pc_src(ex_pc_src),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .mem_req(mem_req), .mem_ack(mem_ack),
        .if_stall(if_stall), .de_stall(de_stall), .ex_stall(ex_stall), .mem_stall(mem_stall),
        .de_clear(de_clear), .ex_clear(ex_clear), .wb_clear(wb_clear),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_error(mem_error),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        de_rs1 = 0; de_rs2 = 0; ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0;
        mem_rd = 0; wb_rd = 0;
        ex_is_load = 0; ex_pc_src = 0; mem_reg_write = 0; wb_reg_write = 0;
        mem_req = 0; mem_ack = 0;
    endtask

    initial begin
        clear_inputs();
        reset_n = 1'b0;
        // Reset state; forwarding still follows its inputs
        mem_reg_write = 1; mem_rd = 3; ex_rs1 = 3;
        #2;
        chk("rst_ctrl", ctrl, C_FLUSH);
        chk("rst_err", mem_error, 0);
        chk("rst_stall_cnt", stall_cycles, 0);
        chk("rst_flush_cnt", flush_count, 0);
        chk("rst_fwd_a", fwd_a, 2'b10);
        clear_inputs();

        // Boot flush: two rising edges with clears, then RUN
        #10 reset_n = 1'b1;          // t=12, first edge with reset high at 15
        #1;
        chk("boot_c0", ctrl, C_FLUSH);
        tick();
        chk("boot_c1", ctrl, C_FLUSH);
        tick();
        chk("boot_done", ctrl, C_NONE);
        chk("boot_stall_cnt", stall_cycles, 0);

        // Load-use on rs2
        ex_is_load = 1; ex_rd = 5; de_rs2 = 5; #1;
        chk("lduse", ctrl, C_LDUSE);
        tick();
        chk("lduse_cnt", stall_cycles, 1);
        ex_rd = 0; #1;
        chk("lduse_x0", ctrl, C_NONE);
        tick();
        chk("lduse_x0_cnt", stall_cycles, 1);

        // Branch beats load-use
        ex_rd = 5; ex_pc_src = 1; #1;
        chk("br_lduse", ctrl, C_FLUSH);
        tick();
        chk("br_flush_cnt", flush_count, 1);
        chk("br_stall_cnt", stall_cycles, 1);
        ex_is_load = 0; de_rs2 = 0; ex_rd = 0;

        // Memory wait of 3 cycles with a branch held in EX
        mem_req = 1; #1;
        chk("mw_c1", ctrl, C_FREEZE);
        tick();
        chk("mw_c2", ctrl, C_FREEZE);
        tick();
        chk("mw_c3", ctrl, C_FREEZE);
        tick();
        mem_ack = 1; #1;
        chk("mw_ack", ctrl, C_FLUSH);
        tick();
        chk("mw_stall_cnt", stall_cycles, 4);
        chk("mw_flush_cnt", flush_count, 2);
        mem_req = 0; mem_ack = 0; ex_pc_src = 0; #1;
        chk("mw_idle", ctrl, C_NONE);

        // Forwarding priority
        mem_rd = 7; ex_rs1 = 7; wb_rd = 7; mem_reg_write = 1; wb_reg_write = 1; #1;
        chk("fwd_a_mem", fwd_a, 2'b10);
        chk("fwd_b_none", fwd_b, 2'b00);
        mem_reg_write = 0; ex_rs2 = 7; #1;
        chk("fwd_a_wb", fwd_a, 2'b01);
        chk("fwd_b_wb", fwd_b, 2'b01);
        wb_rd = 0; ex_rs1 = 0; ex_rs2 = 0; #1;
        chk("fwd_a_x0", fwd_a, 2'b00);
        clear_inputs();

        // Timeout: freeze 4 cycles, then sticky error and release
        mem_req = 1; #1;
        chk("to_c1", ctrl, C_FREEZE);
        tick();
        chk("to_c2", ctrl, C_FREEZE);
        tick();
        chk("to_c3", ctrl, C_FREEZE);
        tick();
        chk("to_c4", ctrl, C_FREEZE);
        chk("to_err_pre", mem_error, 0);
        tick();
        chk("to_err", mem_error, 1);
        chk("to_release", ctrl, C_NONE);
        chk("to_stall_cnt", stall_cycles, 8);
        tick();
        chk("to_blocked", ctrl, C_NONE);
        chk("to_err_sticky", mem_error, 1);
        mem_req = 0;
        tick();
        mem_req = 1; #1;
        chk("to_reenter", ctrl, C_FREEZE);
        tick();
        tick();
        chk("to_mid_wait", ctrl, C_FREEZE);

        // Asynchronous reset mid-wait
        #2 reset_n = 1'b0;
        #1;
        chk("rst_mid_ctrl", ctrl, C_FLUSH);
        chk("rst_mid_err", mem_error, 0);
        chk("rst_mid_cnt", stall_cycles, 0);
        clear_inputs();
        #2 reset_n = 1'b1;
        tick();
        tick();
        chk("reboot", ctrl, C_NONE);

        // Saturate stall_cycles with a persistent load-use stall
        ex_is_load = 1; ex_rd = 9; de_rs1 = 9;
        for (int i = 0; i < 14; i++) tick();
        chk("sat_14", stall_cycles, 14);
        tick();
        chk("sat_15", stall_cycles, 15);
        for (int i = 0; i < 5; i++) tick();
        chk("sat_hold", stall_cycles, 15);
        chk("sat_flush", flush_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
